md_unit: RTL
============

Name: md_unit

Overview:
Multiply/divide unit in the EX stage of the five-stage pipelined MIPS core. It sits directly downstream of the ID/EX pipeline register and consumes its operands. It runs the MIPS mult/multu/div/divu operations over several cycles and holds the HI/LO architectural registers. It also exposes a busy flag, which the hazard logic uses to stall later mult/div/mfhi/mflo/mthi/mtlo instructions in ID.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  core clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  launch the operation selected by op, for one cycle
op  input  2  operation: 0 mult, 1 multu, 2 div, 3 divu
src_a  input  32  rs operand (multiplicand or dividend)
src_b  input  32  rt operand (multiplier or divisor)
we_hi  input  1  mthi write strobe
we_lo  input  1  mtlo write strobe
wdata  input  32  data for mthi/mtlo
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset values (reset low): busy=0, hi=0, lo=0, cnt=0, state IDLE, pending result cleared. Reset takes effect asynchronously, including mid-operation; the in-flight result is discarded.
- Two-state FSM:
  - IDLE -> RUN on a start accepted at edge T.
  - RUN -> IDLE at the edge where the counter reaches 0.
- start acceptance:
  - In IDLE, start at edge T latches src_a, src_b and op.
  - The full 64-bit result is computed combinationally from the latched operands into a pending register.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES.
- Busy timing:
  - busy = (cnt != 0).
  - It is high for exactly N cycles after T, i.e. from T+1 through T+N.
  - cnt decrements once per edge.
- Commit: at the edge where cnt goes 1->0, hi<=result[63:32] and lo<=result[31:0]. New values are visible in the same cycle busy drops.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - div/divu: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Division corner cases:
  - Divisor 0 (div and divu): lo=32'hFFFF_FFFF, hi=src_a.
  - div 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- start while busy: ignored; no relatch, no counter reload. The hazard unit must not issue this.
- mthi/mtlo:
  - In IDLE with start low, we_hi/we_lo write wdata to hi/lo at the edge.
  - Both strobes high writes both registers.
  - While busy, the strobes are ignored.
- Simultaneous start and we_hi/we_lo in IDLE: start wins; the write is dropped.
- op is sampled only on an accepted start.
- Outputs hi/lo/busy are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MULT=2'd0, MD_MULTU=2'd1, MD_DIV=2'd2, MD_DIVU=2'd3;
  - state encodings MD_IDLE/MD_RUN;
  - counter width constant MD_CNT_W=4.
- One sub-module is natural: md_core, the purely combinational 64-bit result generator (op, a, b -> {hi,lo}) including the divide-by-zero and overflow rules.
- md_unit keeps the FSM, counter, operand latches and HI/LO registers.

Test Plan:
1. Reset low mid-RUN (cycle T+3 of a mult) -> busy=0, hi=0, lo=0 immediately. After release, start div 7/2 completes normally with lo=3, hi=1.
2. start mult, src_a=32'hFFFF_FFFE (-2), src_b=3 -> busy high cycles T+1..T+5. At T+5, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. Same operands with multu -> hi=2, lo=32'hFFFF_FFFA.
3. start div, src_a=-7, src_b=2 -> busy 10 cycles, then lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. divu 100/7 -> lo=14, hi=2.
4. divu 5/0 -> lo=32'hFFFF_FFFF, hi=5. div 32'h8000_0000/32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
5. While busy (mult 3x4), pulse start div 9/3 and we_hi with wdata=32'hDEAD_BEEF -> both ignored. Final hi=0, lo=12, and busy drops after exactly 5 cycles.
6. In IDLE, we_lo with wdata=32'h1234_5678 -> lo updates next edge, hi unchanged. Same cycle start mult 2x2 plus we_hi -> we_hi dropped; after 5 cycles hi=0, lo=4.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package md_pkg;

    // Operation encodings as delivered by the decoder
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Width of the busy-cycle counter (cycle counts 1..15)
    localparam int unsigned MD_CNT_W = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Division ops have the upper op bit set
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit result generator: {hi, lo} for mult/multu/div/divu.
module md_core
    import md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Operand conditioning shared by one multiplier and one divider
    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = is_signed && a[31];
        b_neg     = is_signed && b[31];
        // Sign-extend for mult; low 64 bits of the product are then exact
        mul_a     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        mul_b     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product   = mul_a * mul_b;
        // Signed division runs on magnitudes; 0x8000_0000 has magnitude 2^31
        dvd       = a_neg ? (~a + 32'd1) : a;
        dvs       = b_neg ? (~b + 32'd1) : b;
    end

    // Unsigned divide on magnitudes, then restore signs (truncation toward zero)
    always_comb begin
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (dvs != 32'd0) begin
            q_mag = dvd / dvs;
            r_mag = dvd % dvs;
        end
        // 0x8000_0000 / -1: q_mag = 2^31 with both signs negative, so it stays
        // 0x8000_0000 with remainder 0, matching the wrap-around rule
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Select the final {hi, lo} including the divide-by-zero rule
    always_comb begin
        result = 64'd0;
        if (!md_is_div(op)) begin
            result = product;
        end else if (b == 32'd0) begin
            result = {a, 32'hFFFF_FFFF};
        end else begin
            result = {rem, quot};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a busy flag.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MD_CNT_W-1:0] MultLoad = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DivLoad  = MD_CNT_W'(DIV_CYCLES);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [63:0]         pending;

    // Pending result derived from the latched operands
    md_core u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (pending)
    );

    // Next-state: start acceptance, countdown, commit and mthi/mtlo writes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    // start wins over a same-cycle mthi/mtlo
                    op_d    = op;
                    a_d     = src_a;
                    b_d     = src_b;
                    cnt_d   = md_is_div(op) ? DivLoad : MultLoad;
                    state_d = MD_RUN;
                end else begin
                    if (we_hi) hi_d = wdata;
                    if (we_lo) lo_d = wdata;
                end
            end
            MD_RUN: begin
                // start and write strobes are ignored while running
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{(MD_CNT_W-1){1'b0}}, 1'b1}) begin
                    hi_d    = pending[63:32];
                    lo_d    = pending[31:0];
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State register; reset discards any in-flight operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        busy = (cnt_q != '0);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule
